// File: rtl/servisia_gpio_pkg.sv
// Shared register map and bus helpers for the servisia GPIO block.
// Pure definitions: no latency, no backpressure.
package servisia_gpio_pkg;

  localparam int ADDR_W = 4;

  localparam logic [ADDR_W-1:0] REG_OUT   = 4'd0;
  localparam logic [ADDR_W-1:0] REG_DIR   = 4'd1;
  localparam logic [ADDR_W-1:0] REG_IN    = 4'd2;
  localparam logic [ADDR_W-1:0] REG_SET   = 4'd3;
  localparam logic [ADDR_W-1:0] REG_CLR   = 4'd4;
  localparam logic [ADDR_W-1:0] REG_TGL   = 4'd5;
  localparam logic [ADDR_W-1:0] REG_RISE  = 4'd6;
  localparam logic [ADDR_W-1:0] REG_FALL  = 4'd7;
  localparam logic [ADDR_W-1:0] REG_IEN_R = 4'd8;
  localparam logic [ADDR_W-1:0] REG_IEN_F = 4'd9;

  // Expands the four byte-lane enables into a per-bit write mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      m[i] = sel[i/8];
    end
    return m;
  endfunction

endpackage

// File: rtl/servisia_sync.sv
// Multi-flop synchroniser for asynchronous inputs; latency STAGES cycles.
// Free-running, no backpressure; resets to 0.
module servisia_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q_o = stage[STAGES-1];

endmodule

// File: rtl/servisia_gpio.sv
// Wishbone GPIO: direction, atomic set/clr/tgl, sticky edge status, level irq.
// Ack and read data one cycle after stb; never stalls, held stb gives alternating acks.
module servisia_gpio
  import servisia_gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_stb_i,
  output logic [31:0]       wb_rdt_o,
  output logic              wb_ack_o,
  input  logic [WIDTH-1:0]  gpio_i,
  output logic [WIDTH-1:0]  gpio_o,
  output logic [WIDTH-1:0]  gpio_oe_o,
  output logic              irq_o
);

  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int CNT_W   = $clog2(ARM_MAX + 1);

  logic [WIDTH-1:0] out_q, dir_q, rise_q, fall_q, ien_r_q, ien_f_q;
  logic [WIDTH-1:0] sync_q, prev_q;
  logic [CNT_W-1:0] arm_cnt;
  logic             armed;

  logic             access, wr;
  logic [31:0]      lane;
  logic [WIDTH-1:0] wmask, wdat;
  logic [WIDTH-1:0] new_rise, new_fall, clr_rise, clr_fall;
  logic [31:0]      rd_mux;
  logic             unused_bits;

  servisia_sync #(
    .WIDTH (WIDTH),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (gpio_i),
    .q_o   (sync_q)
  );

  assign access = wb_stb_i & ~wb_ack_o;
  assign wr     = access & wb_we_i;

  assign lane        = lane_mask(wb_sel_i);
  assign wmask       = lane[WIDTH-1:0];
  assign wdat        = wb_dat_i[WIDTH-1:0] & wmask;
  assign unused_bits = ^{wb_dat_i, lane};

  // Edges are ignored until the synchroniser and prev flops hold real pad data.
  assign armed    = (arm_cnt == CNT_W'(ARM_MAX));
  assign new_rise = armed ? (sync_q & ~prev_q) : '0;
  assign new_fall = armed ? (prev_q & ~sync_q) : '0;
  assign clr_rise = (wr && wb_adr_i == REG_RISE) ? wdat : '0;
  assign clr_fall = (wr && wb_adr_i == REG_FALL) ? wdat : '0;

  always_comb begin
    rd_mux = 32'd0;
    case (wb_adr_i)
      REG_OUT:   rd_mux = 32'(out_q);
      REG_DIR:   rd_mux = 32'(dir_q);
      REG_IN:    rd_mux = 32'(sync_q);
      REG_RISE:  rd_mux = 32'(rise_q);
      REG_FALL:  rd_mux = 32'(fall_q);
      REG_IEN_R: rd_mux = 32'(ien_r_q);
      REG_IEN_F: rd_mux = 32'(ien_f_q);
      default:   rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q    <= '0;
      dir_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      ien_r_q  <= '0;
      ien_f_q  <= '0;
      prev_q   <= '0;
      arm_cnt  <= '0;
      wb_ack_o <= 1'b0;
      wb_rdt_o <= 32'd0;
      irq_o    <= 1'b0;
    end else begin
      wb_ack_o <= access;
      if (access) begin
        wb_rdt_o <= rd_mux;
      end
      prev_q <= sync_q;
      if (!armed) begin
        arm_cnt <= arm_cnt + CNT_W'(1);
      end
      // A fresh edge wins over a simultaneous write-1-to-clear.
      rise_q <= (rise_q & ~clr_rise) | new_rise;
      fall_q <= (fall_q & ~clr_fall) | new_fall;
      irq_o  <= |((rise_q & ien_r_q) | (fall_q & ien_f_q));
      if (wr) begin
        case (wb_adr_i)
          REG_OUT:   out_q   <= (out_q & ~wmask) | wdat;
          REG_DIR:   dir_q   <= (dir_q & ~wmask) | wdat;
          REG_SET:   out_q   <= out_q | wdat;
          REG_CLR:   out_q   <= out_q & ~wdat;
          REG_TGL:   out_q   <= out_q ^ wdat;
          REG_IEN_R: ien_r_q <= (ien_r_q & ~wmask) | wdat;
          REG_IEN_F: ien_f_q <= (ien_f_q & ~wmask) | wdat;
          default:   ;
        endcase
      end
    end
  end

  assign gpio_o    = out_q;
  assign gpio_oe_o = dir_q;

endmodule

// File: tb/tb_servisia_gpio.sv
// Scoreboard bench for servisia_gpio (WIDTH=16) against a register-level model.
module tb_servisia_gpio;

  localparam int W  = 16;
  localparam int SS = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [3:0]    wb_adr_i = '0;
  logic [31:0]   wb_dat_i = '0;
  logic [3:0]    wb_sel_i = '0;
  logic          wb_we_i = 1'b0;
  logic          wb_stb_i = 1'b0;
  logic [31:0]   wb_rdt_o;
  logic          wb_ack_o;
  logic [W-1:0]  gpio_i = '1;
  logic [W-1:0]  gpio_o;
  logic [W-1:0]  gpio_oe_o;
  logic          irq_o;

  always #5 clk_i = ~clk_i;

  servisia_gpio #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_sel_i (wb_sel_i),
    .wb_we_i  (wb_we_i),
    .wb_stb_i (wb_stb_i),
    .wb_rdt_o (wb_rdt_o),
    .wb_ack_o (wb_ack_o),
    .gpio_i   (gpio_i),
    .gpio_o   (gpio_o),
    .gpio_oe_o(gpio_oe_o),
    .irq_o    (irq_o)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          chk;
    logic [3:0]  adr;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  // Reference model: register contents as seen by software.
  logic [W-1:0] m_out, m_dir, m_rise, m_fall, m_ienr, m_ienf, m_pins;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic model_reset();
    m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_ienr = '0; m_ienf = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a)
      4'd0:    return 32'(m_out);
      4'd1:    return 32'(m_dir);
      4'd2:    return 32'(m_pins);
      4'd6:    return 32'(m_rise);
      4'd7:    return 32'(m_fall);
      4'd8:    return 32'(m_ienr);
      4'd9:    return 32'(m_ienf);
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] sel);
    logic [W-1:0] m, v;
    for (int i = 0; i < W; i++) m[i] = sel[i/8];
    v = d[W-1:0] & m;
    case (a)
      4'd0: m_out  = (m_out & ~m) | v;
      4'd1: m_dir  = (m_dir & ~m) | v;
      4'd3: m_out  = m_out | v;
      4'd4: m_out  = m_out & ~v;
      4'd5: m_out  = m_out ^ v;
      4'd6: m_rise = m_rise & ~v;
      4'd7: m_fall = m_fall & ~v;
      4'd8: m_ienr = (m_ienr & ~m) | v;
      4'd9: m_ienf = (m_ienf & ~m) | v;
      default: ;
    endcase
  endtask

  function automatic logic model_irq();
    return |((m_rise & m_ienr) | (m_fall & m_ienf));
  endfunction

  // Issues a request at the current time; expected response queued first.
  task automatic bus_drive(input logic [3:0] a, input logic we, input logic [31:0] d,
                           input logic [3:0] sel);
    exp_t e;
    e.chk = !we;
    e.adr = a;
    e.val = model_read(a);
    sb.push_back(e);
    if (we) model_write(a, d, sel);
    wb_adr_i = a; wb_we_i = we; wb_dat_i = d; wb_sel_i = sel; wb_stb_i = 1'b1;
  endtask

  task automatic bus(input logic [3:0] a, input logic we, input logic [31:0] d,
                     input logic [3:0] sel);
    @(negedge clk_i);
    bus_drive(a, we, d, sel);
    @(posedge clk_i);
    @(negedge clk_i);
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic set_pins(input logic [W-1:0] nv);
    @(negedge clk_i);
    m_rise = m_rise | (~m_pins & nv);
    m_fall = m_fall | (m_pins & ~nv);
    m_pins = nv;
    gpio_i = nv;
    repeat (5) @(negedge clk_i);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".gpio_o"}, 32'(gpio_o), 32'(m_out));
    chk({tag, ".gpio_oe_o"}, 32'(gpio_oe_o), 32'(m_dir));
    chk({tag, ".irq_o"}, 32'(irq_o), 32'(model_irq()));
  endtask

  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (rst_ni && wb_ack_o) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack: got ack=1 expected no pending request");
      end else begin
        e = sb.pop_front();
        if (e.chk) chk($sformatf("rdt[adr=%0d]", e.adr), wb_rdt_o, e.val);
      end
    end
  end

  initial begin : timeout
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish before 1ms");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  a;
    logic        we;
    logic [31:0] d;
    logic [3:0]  sel;
    exp_t        e;

    model_reset();
    m_pins = '1;
    gpio_i = '1;
    repeat (3) @(negedge clk_i);
    chk("reset.gpio_o", 32'(gpio_o), 32'd0);
    chk("reset.gpio_oe_o", 32'(gpio_oe_o), 32'd0);
    chk("reset.ack", 32'(wb_ack_o), 32'd0);
    chk("reset.rdt", wb_rdt_o, 32'd0);
    chk("reset.irq", 32'(irq_o), 32'd0);

    // Pins high through reset: IN follows after two cycles, no edge recorded.
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    bus(4'd2, 1'b0, 32'd0, 4'hF);
    repeat (4) @(negedge clk_i);
    bus(4'd6, 1'b0, 32'd0, 4'hF);
    bus(4'd7, 1'b0, 32'd0, 4'hF);

    // Byte lanes and single-cycle ack.
    @(negedge clk_i);
    bus_drive(4'd0, 1'b1, 32'h0000A5C3, 4'b0001);
    @(posedge clk_i);
    @(negedge clk_i);
    wb_stb_i = 1'b0; wb_we_i = 1'b0;
    chk("lane.gpio_o", 32'(gpio_o), 32'h000000C3);
    chk("lane.ack_hi", 32'(wb_ack_o), 32'd1);
    @(negedge clk_i);
    chk("lane.ack_lo", 32'(wb_ack_o), 32'd0);
    bus(4'd0, 1'b0, 32'd0, 4'hF);

    // Atomic set/clear/toggle.
    bus(4'd0, 1'b1, 32'h0000000F, 4'hF);
    bus(4'd3, 1'b1, 32'h000000F0, 4'hF);
    chk("set.gpio_o", 32'(gpio_o), 32'h000000FF);
    bus(4'd4, 1'b1, 32'h00000003, 4'hF);
    chk("clr.gpio_o", 32'(gpio_o), 32'h000000FC);
    bus(4'd5, 1'b1, 32'h000000FF, 4'hF);
    chk("tgl.gpio_o", 32'(gpio_o), 32'h00000003);
    bus(4'd3, 1'b0, 32'd0, 4'hF);
    bus(4'd4, 1'b0, 32'd0, 4'hF);
    bus(4'd5, 1'b0, 32'd0, 4'hF);
    bus(4'd1, 1'b1, 32'h00005A3C, 4'hF);
    chk("dir.gpio_oe_o", 32'(gpio_oe_o), 32'h00005A3C);

    // Rising edge on pin 0 with IEN_R[0]: status then irq one cycle later.
    set_pins('0);
    bus(4'd7, 1'b1, 32'h0000FFFF, 4'hF);
    bus(4'd8, 1'b1, 32'h00000001, 4'hF);
    @(negedge clk_i);
    gpio_i[0] = 1'b1;
    m_pins[0] = 1'b1;
    m_rise[0] = 1'b1;
    repeat (SS + 1) @(posedge clk_i);
    @(negedge clk_i);
    chk("edge.irq_pre", 32'(irq_o), 32'd0);
    @(negedge clk_i);
    chk("edge.irq_hi", 32'(irq_o), 32'd1);
    bus(4'd6, 1'b0, 32'd0, 4'hF);
    bus(4'd6, 1'b1, 32'h00000001, 4'hF);
    chk("w1c.irq_hold", 32'(irq_o), 32'd1);
    @(negedge clk_i);
    chk("w1c.irq_lo", 32'(irq_o), 32'd0);
    set_pins('0);
    chk("fall.irq", 32'(irq_o), 32'd0);
    bus(4'd7, 1'b0, 32'd0, 4'hF);
    bus(4'd6, 1'b0, 32'd0, 4'hF);

    // W1C of RISE[2] lands on the same edge that detects a new rise on pin 2.
    set_pins(16'h0004);
    set_pins(16'h0000);
    @(negedge clk_i);
    gpio_i = 16'h0004;
    m_pins = 16'h0004;
    repeat (SS) @(posedge clk_i);
    @(negedge clk_i);
    bus_drive(4'd6, 1'b1, 32'h00000004, 4'hF);
    m_rise[2] = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    wb_stb_i = 1'b0; wb_we_i = 1'b0;
    bus(4'd6, 1'b0, 32'd0, 4'hF);

    // Randomised traffic against the model.
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        set_pins(W'($urandom));
      end else begin
        a   = 4'($urandom_range(0, 15));
        we  = 1'($urandom_range(0, 1));
        d   = $urandom;
        sel = 4'($urandom_range(0, 15));
        bus(a, we, d, sel);
        @(negedge clk_i);
      end
      check_outputs("rand");
    end

    // Held stb on an unmapped address: alternating acks, read data 0.
    @(negedge clk_i);
    chk("held.ack0", 32'(wb_ack_o), 32'd0);
    for (int k = 0; k < 2; k++) begin
      e.chk = 1'b1; e.adr = 4'd12; e.val = 32'd0;
      sb.push_back(e);
    end
    wb_adr_i = 4'd12; wb_we_i = 1'b0; wb_sel_i = 4'hF; wb_stb_i = 1'b1;
    @(negedge clk_i);
    chk("held.ack1", 32'(wb_ack_o), 32'd1);
    @(negedge clk_i);
    chk("held.ack2", 32'(wb_ack_o), 32'd0);
    @(negedge clk_i);
    chk("held.ack3", 32'(wb_ack_o), 32'd1);
    wb_stb_i = 1'b0;
    bus(4'd12, 1'b1, 32'hFFFFFFFF, 4'hF);
    bus(4'd14, 1'b1, 32'hFFFFFFFF, 4'hF);
    for (int r = 0; r < 10; r++) bus(4'(r), 1'b0, 32'd0, 4'hF);
    @(negedge clk_i);
    check_outputs("unmapped");

    // Async reset while ack is high.
    @(negedge clk_i);
    bus_drive(4'd0, 1'b1, 32'h0000FFFF, 4'hF);
    @(posedge clk_i);
    #1;
    chk("rst.ack_before", 32'(wb_ack_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("rst.ack_drop", 32'(wb_ack_o), 32'd0);
    chk("rst.rdt", wb_rdt_o, 32'd0);
    chk("rst.gpio_o", 32'(gpio_o), 32'd0);
    wb_stb_i = 1'b0; wb_we_i = 1'b0;
    sb.delete();
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (6) @(negedge clk_i);
    bus(4'd2, 1'b0, 32'd0, 4'hF);
    bus(4'd6, 1'b0, 32'd0, 4'hF);
    bus(4'd7, 1'b0, 32'd0, 4'hF);
    bus(4'd0, 1'b0, 32'd0, 4'hF);
    @(negedge clk_i);
    check_outputs("post_rst");

    repeat (2) @(negedge clk_i);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/servisia_gpio.md
Name: servisia_gpio

Overview:
- Parametrised successor to the output-only GPO peripheral on the servisia Wishbone peripheral port.
- Adds per-pin direction control, synchronised inputs, atomic set/clear/toggle, sticky rising/falling-edge status and a level interrupt.
- Sits between subservient_core's o_wb_*/i_wb_* interface and the board pins.
- Ack timing matches the existing GPO, so it drops in place.

Parameters:
WIDTH, 8, number of pins; legal range 1..32.
SYNC_STAGES, 2, input synchroniser depth; must be >= 2.

Ports:
clk_i  input  1  clock.
rst_ni  input  1  asynchronous active-low reset.
wb_adr_i  input  4  word register index; top connects core adr[5:2].
wb_dat_i  input  32  write data.
wb_sel_i  input  4  byte-lane write enables.
wb_we_i  input  1  write strobe qualifier.
wb_stb_i  input  1  request.
wb_rdt_o  output  32  registered read data; bits above WIDTH read 0.
wb_ack_o  output  1  one-cycle acknowledge.
gpio_i  input  WIDTH  pad inputs, asynchronous.
gpio_o  output  WIDTH  output data (OUT register).
gpio_oe_o  output  WIDTH  output enable (DIR register, 1 = drive).
irq_o  output  1  registered level interrupt.

Behaviour:
- Reset (rst_ni low, asynchronous): OUT, DIR, RISE, FALL, IEN_R, IEN_F, all synchroniser flops, prev-sample, arm counter, wb_ack_o, wb_rdt_o and irq_o are 0.
- Register map (wb_adr_i):
  - 0 OUT: read/write.
  - 1 DIR: read/write.
  - 2 IN: read only, synchronised pad value.
  - 3 SET: write-only, OUT |= d.
  - 4 CLR: write-only, OUT &= ~d.
  - 5 TGL: write-only, OUT ^= d.
  - 6 RISE: write-1-to-clear.
  - 7 FALL: write-1-to-clear.
  - 8 IEN_R: read/write.
  - 9 IEN_F: read/write.
  - 10..15: unmapped; ack, read 0, writes ignored.
  - SET/CLR/TGL read 0.
- Byte lanes: a write affects bit i only if wb_sel_i[i/8]=1; d is wb_dat_i masked the same way.
- Handshake:
  - Next-state ack = wb_stb_i & ~wb_ack_o.
  - stb first seen at cycle N (ack low) -> ack=1 and wb_rdt_o valid at N+1.
  - Write takes effect at the same edge, so it is visible on gpio_o/gpio_oe_o at N+1.
  - Master drops stb after ack. If stb stays high, ack alternates 0/1 and each ack is a fresh access.
  - wb_rdt_o holds its value when not acking.
- Synchroniser: SYNC_STAGES flops per pin. IN reflects gpio_i SYNC_STAGES cycles later, regardless of DIR.
- Edge detect:
  - prev <= sync each cycle.
  - RISE[i] set when prev=0 & sync=1; FALL[i] set when prev=1 & sync=0.
  - Arming: a counter suppresses edge capture until SYNC_STAGES+1 cycles after reset release, so a pin tied high at reset records no edge.
  - Set priority: a new edge and a W1C of the same bit in the same cycle leaves the bit set.
- irq_o registered: irq_o <= |((RISE & IEN_R) | (FALL & IEN_F)). Asserts one cycle after the status/enable condition; deasserts one cycle after the clear.
- Reset mid-transaction: ack and rdt drop immediately; the in-flight write is lost.
- WIDTH=32: no padding. WIDTH<32: upper wb_dat_i bits ignored.

Decomposition:
- Package servisia_gpio_pkg:
  - Register index localparams (REG_OUT=0 ... REG_IEN_F=9).
  - Address width constant (4).
- Sub-module servisia_sync:
  - Parameters WIDTH, STAGES; ports clk_i, rst_ni, d_i, q_o.
  - Reset value 0; reused later for other async inputs.
- Rest in one module: bus decode, register file, edge/arm logic, irq register.

Test Plan:
- Reset/arm: gpio_i=8'hFF held through reset.
  - Outputs all 0; ack 0.
  - After 2 cycles IN reads 8'hFF.
  - RISE reads 0 after arming.
- Bus timing/byte lanes (WIDTH=16):
  - Write OUT=32'hA5C3 with sel=4'b0001 -> gpio_o=16'h00C3 one cycle after stb.
  - ack high exactly one cycle.
  - Read OUT returns 32'h000000C3 with ack.
- Atomic ops: OUT=8'h0F.
  - SET 8'hF0 -> gpio_o=8'hFF.
  - CLR 8'h03 -> 8'hFC.
  - TGL 8'hFF -> 8'h03.
  - Reads of addr 3/4/5 return 0.
- Edges/IRQ: IEN_R=8'h01; pulse gpio_i[0] 0->1.
  - RISE=8'h01 after SYNC_STAGES+1 cycles.
  - irq_o high one cycle later.
  - W1C 8'h01 clears RISE; irq_o low next cycle.
  - FALL=8'h01 on release, no irq (IEN_F=0).
- Simultaneous clear and edge: W1C RISE[2] in the same cycle a new rising edge on pin 2 is detected -> RISE[2] remains 1.
- Held stb and unmapped address:
  - stb held 4 cycles on addr 12 -> ack pattern 0,1,0,1.
  - Read data 0; no register changes.
  - Async reset asserted while ack=1 -> ack drops immediately.
